seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_div_pkg.sv | 9 +
 rtl/seq_div_ctrl.sv | 47 ++++
 rtl/seq_divider.sv | 128 ++++++++++++
 tb/tb_seq_divider.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared 3-bit FSM state encoding for seq_divider and seq_div_ctrl.
package seq_div_pkg;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_LOAD = 3'd1;
   localparam state_t S_ITER = 3'd2;
   localparam state_t S_FIX  = 3'd3;
   localparam state_t S_DONE = 3'd4;
endpackage

// File: rtl/seq_div_ctrl.sv
// seq_div_ctrl: sequencing FSM for seq_divider (IDLE, LOAD, ITER, FIX, DONE).
//   clk, rst (async, active-high)
//   start : request, honoured only in IDLE
//   zero  : captured divisor is zero (checked in LOAD)
//   last  : current ITER step is the final one
//   load, step, fix, done : one-hot state strobes for the datapath
//   busy  : any state other than IDLE
// SEQ_DIVIDER_SIGNED_EN adds the FIX state between ITER and DONE.
module seq_div_ctrl
   import seq_div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic zero,
   input  logic last,
   output logic load,
   output logic step,
   output logic fix,
   output logic done,
   output logic busy
);
`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam state_t S_POST = S_FIX;
`else
   localparam state_t S_POST = S_DONE;
`endif
   state_t state_q, state_d;
   always_comb begin
      state_d = (state_q == S_IDLE) ? (start ? S_LOAD : S_IDLE) :
                (state_q == S_LOAD) ? (zero ? S_DONE : S_ITER) :
                (state_q == S_ITER) ? (last ? S_POST : S_ITER) :
                (state_q == S_FIX)  ? S_DONE : S_IDLE;
      load = state_q == S_LOAD;
      step = state_q == S_ITER;
`ifdef SEQ_DIVIDER_SIGNED_EN
      fix  = state_q == S_FIX;
`else
      fix  = 1'b0;
`endif
      done = state_q == S_DONE;
      busy = state_q != S_IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock, MSB first.
//   WIDTH        : operand/result width (2..32)
//   clk, rst     : clock, async active-high reset
//   start        : request, accepted only while not busy; operands captured then
//   dividend, divisor : operands
//   quotient, remainder : registered results, valid from the done pulse
//   busy         : operation in flight
//   done         : one-cycle completion pulse
//   div_by_zero  : last completed operation had a zero divisor
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operation (one extra cycle).
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d;
   logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d, a_mag, b_mag, rem_sub;
   logic [WIDTH:0]   rem_sh;
   logic [5:0]       cnt_q, cnt_d;
   logic             z_q, z_d, dbz_q, dbz_d, done_q, done_d;
   logic             load, step, fix, done_st, busy_w, zero, last, ge;
   seq_div_ctrl u_ctrl (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .zero  (zero),
      .last  (last),
      .load  (load),
      .step  (step),
`ifdef SEQ_DIVIDER_SIGNED_EN
      .fix   (fix),
`else
      .fix   (),
`endif
      .done  (done_st),
      .busy  (busy_w)
   );
`ifndef SEQ_DIVIDER_SIGNED_EN
   assign fix = 1'b0;
`endif
   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      a_mag = a_q[WIDTH-1] ? -a_q : a_q;
      b_mag = b_q[WIDTH-1] ? -b_q : b_q;
`else
      a_mag = a_q;
      b_mag = b_q;
`endif
      zero    = b_q == '0;
      last    = cnt_q == 6'(WIDTH - 1);
      rem_sh  = {rem_q, dvd_q[WIDTH-1]};
      ge      = rem_sh >= {1'b0, dsr_q};
      // the true difference is below dsr_q, so WIDTH bits suffice
      rem_sub = rem_sh[WIDTH-1:0] - dsr_q;
      a_d     = (start && !busy_w) ? dividend : a_q;
      b_d     = (start && !busy_w) ? divisor : b_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      if (load) begin
         dsr_d = b_mag;
         cnt_d = '0;
         z_d   = zero;
         dvd_d = zero ? '1 : a_mag;
         rem_d = zero ? a_q : '0;
      end
      // dividend bits shift out the top while quotient bits shift in the bottom
      if (step) begin
         dvd_d = {dvd_q[WIDTH-2:0], ge};
         rem_d = ge ? rem_sub : rem_sh[WIDTH-1:0];
         cnt_d = cnt_q + 6'd1;
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (fix) begin
         dvd_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -dvd_q : dvd_q;
         rem_d = a_q[WIDTH-1] ? -rem_q : rem_q;
      end
`endif
      quotient_d  = done_st ? dvd_q : quotient_q;
      remainder_d = done_st ? rem_q : remainder_q;
      dbz_d       = load ? 1'b0 : done_st ? z_q : dbz_q;
      done_d      = done_st;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         z_q         <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         dvd_q       <= dvd_d;
         dsr_q       <= dsr_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         z_q         <= z_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         done_q      <= done_d;
      end
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = busy_w;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider, random and directed operands vs. an arithmetic model.
module tb_seq_divider;
   localparam int W = 8;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;
   logic [W-1:0] quotient, remainder;
   logic busy, done, div_by_zero;
   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
      int           t0;
   } exp_t;
   exp_t sb[$];
   int errors = 0, checks = 0, n_done = 0, cyc = 0;
   logic [W-1:0] last_q = '0, last_r = '0;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int qi, ri;
`ifdef SEQ_DIVIDER_SIGNED_EN
      e.lat = W + 3;
`else
      e.lat = W + 2;
`endif
      e.t0 = 0;
      if (b == '0) begin
         e.q = '1; e.r = a; e.z = 1'b1; e.lat = 2;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         qi = int'($signed(a)) / int'($signed(b));
         ri = int'($signed(a)) % int'($signed(b));
`else
         qi = int'(a) / int'(b);
         ri = int'(a) % int'(b);
`endif
         e.q = qi[W-1:0]; e.r = ri[W-1:0]; e.z = 1'b0;
      end
      return e;
   endfunction

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (done === 1'b1) begin
         n_done++;
         if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
            chk("latency", 32'(cyc - e.t0), 32'(e.lat));
            last_q = e.q;
            last_r = e.r;
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk);
      #1;
      e = model(a, b);
      e.t0 = cyc;
      sb.push_back(e);
      start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
   endtask

   task automatic wait_done();
      int n0 = n_done;
      int k = 0;
      while (n_done == n0 && k < 40) begin
         @(posedge clk);
         k++;
      end
      if (n_done == n0) begin
         chk("done_timeout", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
      issue(a, b);
      wait_done();
   endtask

   initial begin
      logic [W-1:0] a, b;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      #1 rst = 1'b0;
      run(8'd100, 8'd7);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_quotient", 32'(quotient), 32'(last_q));
      chk("hold_remainder", 32'(remainder), 32'(last_r));
      run(8'd5, 8'd0);
      run(8'd255, 8'd1);
      run(8'd3, 8'd200);
      run(8'h9C, 8'd7);
      run(8'h80, 8'hFF);
      run(8'd0, 8'd5);
      run(8'd0, 8'd0);
      issue(8'd200, 8'd3);
      repeat (3) begin
         @(negedge clk);
         start = 1'b1; dividend = W'($urandom); divisor = W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      wait_done();
      issue(8'd77, 8'd5);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_quotient", 32'(quotient), 32'd0);
      chk("abort_remainder", 32'(remainder), 32'd0);
      chk("abort_dbz", 32'(div_by_zero), 32'd0);
      sb.delete();
      #1 rst = 1'b0;
      run(8'd60, 8'd7);
      repeat (24) begin
         a = W'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         run(a, b);
      end
      repeat (5) @(posedge clk);
      if (sb.size() != 0) chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
